// File: rtl/led_mode_controller.sv
// LED pattern sequencer: debounced buttons select the mode, speed and pause state;
// a programmable down-counter paces the pattern steps.
module led_mode_controller #(
  parameter int unsigned CLK_HZ          = 125000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic [1:0] speed,
  output logic       paused,
  output logic       tick
);

  localparam int unsigned NBTN  = 4;
  localparam int unsigned CNT_W = $clog2(CLK_HZ);
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);

  localparam int unsigned BTN_NEXT  = 0;
  localparam int unsigned BTN_UP    = 1;
  localparam int unsigned BTN_DOWN  = 2;
  localparam int unsigned BTN_PAUSE = 3;

  typedef enum logic [1:0] {
    MODE_BINARY = 2'd0,
    MODE_SCAN   = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_GRAY   = 2'd3
  } mode_e;

  // Tick reload value for a given speed index.
  function automatic logic [CNT_W-1:0] period_m1(input logic [1:0] s);
    return CNT_W'((CLK_HZ >> s) - 32'd1);
  endfunction

  logic [NBTN-1:0] press;

  // Per-button synchroniser and debouncer; press pulses on an accepted rising level.
  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    logic            s1;
    logic            s2;
    logic            lvl;
    logic            evt;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk) begin
      if (reset) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        lvl <= 1'b0;
        evt <= 1'b0;
        cnt <= '0;
      end else begin
        s1  <= btn[g];
        s2  <= s1;
        evt <= 1'b0;
        if (s2 == lvl) begin
          cnt <= '0;
        end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          lvl <= s2;
          evt <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + DB_W'(1);
        end
      end
    end

    assign press[g] = evt;
  end

  mode_e            mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dir_up_q;
  logic [3:0]       gray_b_q;

  logic [1:0]       speed_n_c;
  logic             speed_chg_c;
  logic             expire_c;
  logic [CNT_W-1:0] reload_c;
  mode_e            mode_n_c;
  logic [3:0]       led_init_c;
  logic [3:0]       led_adv_c;
  logic             dir_adv_c;
  logic [3:0]       gray_adv_c;

  assign mode = mode_q;

  // Saturating speed update; simultaneous up and down cancel.
  always_comb begin
    speed_n_c = speed;
    if (press[BTN_UP] && !press[BTN_DOWN] && speed != 2'd3) begin
      speed_n_c = speed + 2'd1;
    end else if (press[BTN_DOWN] && !press[BTN_UP] && speed != 2'd0) begin
      speed_n_c = speed - 2'd1;
    end
  end

  assign speed_chg_c = (speed_n_c != speed);
  assign expire_c    = (cnt_q == '0) && !paused;
  assign reload_c    = period_m1(speed_n_c);
  assign mode_n_c    = mode_e'(mode_q + 2'd1);
  assign led_init_c  = (mode_n_c == MODE_SCAN) ? 4'b0001 : 4'b0000;

  // Next pattern value for the current mode.
  always_comb begin
    led_adv_c  = led;
    dir_adv_c  = dir_up_q;
    gray_adv_c = gray_b_q;
    case (mode_q)
      MODE_BINARY: led_adv_c = led + 4'd1;
      MODE_SCAN: begin
        if (dir_up_q) begin
          if (led[3]) begin
            led_adv_c = 4'b0100;
            dir_adv_c = 1'b0;
          end else begin
            led_adv_c = {led[2:0], 1'b0};
          end
        end else begin
          if (led[0]) begin
            led_adv_c = 4'b0010;
            dir_adv_c = 1'b1;
          end else begin
            led_adv_c = {1'b0, led[3:1]};
          end
        end
      end
      MODE_BLINK: led_adv_c = ~led;
      MODE_GRAY: begin
        gray_adv_c = gray_b_q + 4'd1;
        led_adv_c  = gray_adv_c ^ (gray_adv_c >> 1);
      end
    endcase
  end

  // Mode/pattern state, tick scheduler and pause control.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= MODE_BINARY;
      led      <= 4'b0000;
      speed    <= 2'd0;
      paused   <= 1'b0;
      tick     <= 1'b0;
      dir_up_q <= 1'b1;
      gray_b_q <= 4'd0;
      cnt_q    <= period_m1(2'd0);
    end else begin
      tick  <= 1'b0;
      speed <= speed_n_c;
      if (press[BTN_PAUSE]) begin
        paused <= ~paused;
      end
      // A mode change drops any coincident tick and restarts the period.
      if (press[BTN_NEXT]) begin
        mode_q   <= mode_n_c;
        led      <= led_init_c;
        dir_up_q <= 1'b1;
        gray_b_q <= 4'd0;
        cnt_q    <= reload_c;
      end else if (expire_c) begin
        tick     <= 1'b1;
        led      <= led_adv_c;
        dir_up_q <= dir_adv_c;
        gray_b_q <= gray_adv_c;
        cnt_q    <= reload_c;
      end else if (speed_chg_c) begin
        cnt_q    <= reload_c;
      end else if (!paused) begin
        cnt_q    <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule
